// File: rtl/ctrl_spi_master.sv
`timescale 1ns / 1ps
// ctrl_spi_master
//   SPI master (mode 0, MSB first) that sends one frame of control values to the
//   analog-controls slave. CTRL_SS_n stays low for the whole frame. A frame is
//   LEAD (HALF cycles), 2*HALF cycles per bit, TRAIL (HALF cycles), then a GAP
//   of 2*HALF cycles with SS_n high. done pulses for one cycle at the end of GAP.
//
// Optional feature: define CTRL_SPI_CHECKSUM_EN to append one BITS-wide byte
//   after the last channel. It holds the sum of all channel values mod 2^BITS.
//   When the macro is undefined there is no checksum byte and no adder.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   ch_data    in   N_CH*BITS packed channel values, channel 0 in the MSBs
//   go         in   frame request, accepted only while idle
//   busy       out  high from frame acceptance until done
//   done       out  one-cycle pulse at the end of the inter-frame gap
//   CTRL_SCLK  out  SPI clock, idles low
//   CTRL_MOSI  out  SPI data
//   CTRL_SS_n  out  frame select, active low
module ctrl_spi_master #(
  parameter int BITS  = 8,
  parameter int N_CH  = 8,
  parameter int fCLK  = 50_000_000,
  parameter int fSCLK = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH*BITS-1:0] ch_data,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic                 CTRL_SCLK,
  output logic                 CTRL_MOSI,
  output logic                 CTRL_SS_n
);

  localparam int HALF = fCLK / (2 * fSCLK);
`ifdef CTRL_SPI_CHECKSUM_EN
  localparam int NBITS = (N_CH + 1) * BITS;
`else
  localparam int NBITS = N_CH * BITS;
`endif
  // Half-period counter must reach 2*HALF-1 for the gap.
  localparam int HW = $clog2(2 * HALF);
  localparam int BW = $clog2(NBITS + 1);

  if (HALF < 1 || 2 * HALF * fSCLK != fCLK) begin : g_bad_half
    $error("ctrl_spi_master: fCLK/(2*fSCLK) must be an integer >= 1");
  end

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  state_e           r_state;
  logic [HW-1:0]    r_hcnt;
  logic [BW-1:0]    r_bcnt;
  logic [NBITS-1:0] r_sreg;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_ss_n;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [HW-1:0]    w_hcnt_nxt;
  logic [BW-1:0]    w_bcnt_nxt;
  logic [NBITS-1:0] w_sreg_nxt;
  logic             w_sclk_nxt;
  logic             w_mosi_nxt;
  logic             w_ss_n_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic             w_hcnt_zero;
  logic             w_last_bit;
  logic             w_accept;
  logic [NBITS-1:0] w_frame;

  assign w_hcnt_zero = (r_hcnt == '0);
  assign w_last_bit  = (r_bcnt == BW'(1));
  assign w_accept    = go && !r_busy;

`ifdef CTRL_SPI_CHECKSUM_EN
  logic [BITS-1:0] w_csum;

  // Summed from the same ch_data value that is latched, so it matches the frame.
  always_comb begin
    w_csum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_csum = w_csum + ch_data[i*BITS +: BITS];
    end
  end

  assign w_frame = {ch_data, w_csum};
`else
  assign w_frame = ch_data;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_sreg  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_sreg  <= w_sreg_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StLead;
      StLead:  if (w_hcnt_zero) w_state_nxt = StShift;
      StShift: if (w_hcnt_zero && r_sclk && w_last_bit) w_state_nxt = StTrail;
      StTrail: if (w_hcnt_zero) w_state_nxt = StGap;
      StGap:   if (w_hcnt_zero) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Next values of the counters, shift register and registered outputs.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_bcnt_nxt = r_bcnt;
    w_sreg_nxt = r_sreg;
    w_sclk_nxt = r_sclk;
    w_mosi_nxt = r_mosi;
    w_ss_n_nxt = r_ss_n;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_sreg_nxt = w_frame;
          w_bcnt_nxt = BW'(NBITS);
          w_hcnt_nxt = HW'(HALF - 1);
          w_ss_n_nxt = 1'b0;
          w_sclk_nxt = 1'b0;
          w_mosi_nxt = w_frame[NBITS-1];
          w_busy_nxt = 1'b1;
        end
      end
      StLead: begin
        if (w_hcnt_zero) begin
          w_sclk_nxt = 1'b1;
          w_hcnt_nxt = HW'(HALF - 1);
        end else begin
          w_hcnt_nxt = r_hcnt - 1'b1;
        end
      end
      StShift: begin
        if (w_hcnt_zero) begin
          w_hcnt_nxt = HW'(HALF - 1);
          if (r_sclk) begin
            // Falling edge: advance to the next bit, except after the last one.
            w_sclk_nxt = 1'b0;
            w_bcnt_nxt = r_bcnt - 1'b1;
            if (!w_last_bit) begin
              w_sreg_nxt = r_sreg << 1;
              w_mosi_nxt = r_sreg[NBITS-2];
            end
          end else begin
            w_sclk_nxt = 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt - 1'b1;
        end
      end
      StTrail: begin
        if (w_hcnt_zero) begin
          w_ss_n_nxt = 1'b1;
          w_hcnt_nxt = HW'(2 * HALF - 1);
        end else begin
          w_hcnt_nxt = r_hcnt - 1'b1;
        end
      end
      StGap: begin
        if (w_hcnt_zero) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else begin
          w_hcnt_nxt = r_hcnt - 1'b1;
        end
      end
      default: begin
        w_hcnt_nxt = '0;
        w_bcnt_nxt = '0;
        w_sclk_nxt = 1'b0;
        w_ss_n_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign CTRL_SCLK = r_sclk;
  assign CTRL_MOSI = r_mosi;
  assign CTRL_SS_n = r_ss_n;

endmodule
